// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seg_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {IDLE, GUARD, DRIVE} scan_state_e;
endpackage

// File: rtl/display_driver.sv
// 4-bit code to 7-segment pattern, active-high, bit order {g,f,e,d,c,b,a}.
module display_driver
  import seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] code,
  output logic [6:0]         seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0: seg = 7'b0111111;
      4'd1: seg = 7'b0000110;
      4'd2: seg = 7'b1011011;
      4'd3: seg = 7'b1001111;
      4'd4: seg = 7'b1100110;
      4'd5: seg = 7'b1101101;
      4'd6: seg = 7'b1111101;
      4'd7: seg = 7'b0000111;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1101111;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg_scan_controller.sv
// Scans NUM_DIGITS digits through one decoder with guard blanking, leading-zero
// suppression and a shadow register that commits only at frame boundaries.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD_CYC   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          lz_blank,
  input  logic                          load_valid,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_data,
  output logic                          load_ready,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          frame_done
);
  localparam int DW = DIGIT_W * NUM_DIGITS;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] SLOT_END  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_END = CW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

  scan_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         display_q, shadow_q, disp_eff;
  logic                  full_q, commit;
  logic [NUM_DIGITS-1:0] lz_mask, an_d;
  logic                  upper_zero, fd_d;
  logic [DIGIT_W-1:0]    dec_code;
  logic [6:0]            dec_seg, seg_d;

  assign load_ready = ~full_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = (GUARD_CYC == 0) ? DRIVE : GUARD;
        end
        GUARD: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == GUARD_END) state_d = DRIVE;
        end
        DRIVE: begin
          if (cnt_q == SLOT_END) begin
            cnt_d   = '0;
            idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
            state_d = (GUARD_CYC == 0) ? DRIVE : GUARD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Commit only at a frame boundary (or while dark); the decode path sees the
  // committed value in the same cycle so the next frame is never torn.
  assign commit   = full_q && (frame_done || state_q == IDLE);
  assign disp_eff = commit ? shadow_q : display_q;

  always_comb begin
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (i > 0 && upper_zero && disp_eff[i*DIGIT_W +: DIGIT_W] == '0) lz_mask[i] = 1'b1;
      upper_zero = upper_zero && (disp_eff[i*DIGIT_W +: DIGIT_W] == '0);
    end
  end

  assign dec_code = disp_eff[idx_d*DIGIT_W +: DIGIT_W];

  display_driver u_dec (
    .code (dec_code),
    .seg  (dec_seg)
  );

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = '0;
    fd_d  = (state_d == DRIVE) && (cnt_d == SLOT_END) && (idx_d == LAST_IDX);
    if (state_d == DRIVE) begin
      an_d = NUM_DIGITS'(1) << idx_d;
      if (!(lz_blank && lz_mask[idx_d])) seg_d = dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      display_q  <= '0;
      shadow_q   <= '0;
      full_q     <= 1'b0;
      seg        <= SEG_BLANK;
      an         <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      seg        <= seg_d;
      an         <= an_d;
      frame_done <= fd_d;
      if (commit) begin
        display_q <= shadow_q;
        full_q    <= 1'b0;
      end else if (load_valid && !full_q) begin
        shadow_q <= load_data;
        full_q   <= 1'b1;
      end
    end
  end
endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Time-multiplexes one 4-bit-to-7-segment decoder across NUM_DIGITS common-segment digits.
- Each digit slot drives one digit's code through the decoder and asserts one digit enable.
- Provides anti-ghosting guard blanking, leading-zero suppression, and tear-free atomic frame updates via a valid/ready load port.
- Sits between the value-producing logic (counters, BCD converters) and the board's segment/anode pins.

Parameters:
- NUM_DIGITS, 4, digits scanned; index 0 = least significant; range 2..8
- REFRESH_DIV, 50000, clk cycles per digit slot; minimum 4
- GUARD_CYC, 2, cycles at slot start with all digit enables off; must be < REFRESH_DIV

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- enable  input  1  1 = scanning; 0 = display dark
- lz_blank  input  1  1 = suppress leading zeros
- load_valid  input  1  new frame offered
- load_data  input  4*NUM_DIGITS  digit codes; digit i in bits [4i+3:4i]
- load_ready  output  1  shadow register free to accept a frame
- seg  output  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}
- an  output  NUM_DIGITS  digit enable, one-hot active-high, or all zero
- frame_done  output  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge), all registered:
  - seg=0, an=0, frame_done=0, load_ready=1
  - display register=0, shadow empty, slot counter=0, digit index=0
  - FSM to IDLE
  - Reset mid-frame aborts the frame; no pulse is produced.
- FSM states: IDLE, GUARD, DRIVE.
  - IDLE: an=0, seg=0, counters held at 0. When enable=1, go to GUARD with index 0.
  - GUARD: an=0, seg=0 for GUARD_CYC cycles, then DRIVE.
  - DRIVE: an=(1<<index), seg=decode(display digit[index]) for REFRESH_DIV-GUARD_CYC cycles.
  - At the end of DRIVE: index increments and wraps NUM_DIGITS-1 -> 0; FSM returns to GUARD.
  - enable=0 in any state: next cycle IDLE, an=0, seg=0, index=0, counter=0.
- Slot length is exactly REFRESH_DIV cycles; a full frame is NUM_DIGITS*REFRESH_DIV cycles.
- Latency: outputs are registered and change one cycle after a state/counter transition; no combinational input-to-output path.
- Decoding: the existing display_driver is instantiated once, fed by the index-selected nibble.
  - Codes 0-9 give the standard patterns (e.g. 0 -> 7'b0111111, 8 -> 7'b1111111).
  - Codes 10-15 give seg=0.
- Leading-zero suppression (lz_blank=1):
  - Digit i is blanked (seg=0, an still asserted) iff i>0, digit i==0, and every digit above i is 0.
  - Digit 0 is never suppressed, so all-zero shows "0".
  - Evaluated on the display register, not the shadow.
- Load handshake:
  - A transfer occurs when load_valid && load_ready at a clk edge. load_data is captured into the shadow; load_ready drops to 0 next cycle.
  - The shadow is copied to the display register on the cycle frame_done is asserted; load_ready returns to 1 on the following cycle.
  - If scanning is IDLE, commit happens the cycle after capture.
  - load_valid while load_ready=0 is ignored; the producer must hold it.
  - No frame is ever shown partially: each frame shows a single display-register value.
- frame_done: pulses for exactly one cycle on the last cycle of DRIVE when index=NUM_DIGITS-1. Never asserted in IDLE.
- Simultaneous events:
  - Capture and commit never coincide because load_ready=0 while the shadow is full.
  - enable falling on the frame_done cycle: pulse still issued, commit still happens, then IDLE.
- Width rules:
  - Slot counter width = $clog2(REFRESH_DIV); index width = $clog2(NUM_DIGITS), min 1.
  - Counter compares use full-width constants; no truncation on wrap.

Decomposition:
- Shared package seg_pkg:
  - scan state enum (IDLE, GUARD, DRIVE)
  - SEG_BLANK = 7'b0000000
  - digit width constant DIGIT_W = 4
- Sub-module: the existing display_driver decoder, one instance.
- Leading-zero mask and handshake logic stay inline.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYC=1):
- Reset then enable=1, no load -> an sequence 0000,0001,0000,0010,0000,0100,0000,1000 with guard 1 cycle and drive 3 cycles; digit 0 shows seg=7'b0111111; frame_done pulses every 16 cycles.
- Load 16'h1234 while scanning mid-frame -> load_ready=0 the next cycle; old value shown until frame_done; next frame an=0001 shows 4 (7'b1100110) and an=1000 shows 1 (7'b0000110); load_ready=1 one cycle after the pulse.
- lz_blank=1, load 16'h0070 -> digits 3 and 2 seg=0 with an still stepping, digit 1 shows 7 (7'b0000111), digit 0 shows 0; then load 16'h0000 -> only digit 0 shows 0.
- Load 16'hFA09 -> digits 3 and 2 seg=0 (invalid codes), digit 1 shows 0, digit 0 shows 9 (7'b1101111).
- enable dropped mid-DRIVE of digit 2 -> next cycle an=0, seg=0, no frame_done; re-enable restarts at digit 0 after a 1-cycle guard.
- rst_n=0 asserted with shadow full -> next cycle load_ready=1, display=0, an=0; a second load_valid held across a busy window is accepted exactly once.
